// File: rtl/pll_lock_monitor.sv
// Measured PLL lock detector: counts reference-clock edges over a fixed window of
// clk cycles and declares lock after a run of in-tolerance windows.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | measurement disabled, counters cleared, locked low
// S_ACQUIRE| measuring, collecting consecutive good windows
// S_LOCKED | lock declared; any bad window drops back to S_ACQUIRE
module pll_lock_monitor #(
   parameter int WINDOW       = 1200,
   parameter int EXPECTED     = 120,
   parameter int TOLERANCE    = 2,
   parameter int GOOD_WINDOWS = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ref_clk_in,
   input  logic             enable,
   output logic             locked,
   output logic [CNT_W-1:0] freq_count,
   output logic             count_valid,
   output logic             lost_lock
);

   localparam int WIN_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACQUIRE = 2'd1,
      S_LOCKED  = 2'd2
   } state_t;

   state_t            state;
   logic              ref_sync1;
   logic              ref_sync2;
   logic              ref_hist;
   logic [1:0]        prime_cnt;
   logic [WIN_W-1:0]  win_cnt;
   logic [CNT_W-1:0]  edge_cnt;
   logic [GOOD_W-1:0] good_cnt;

   logic              edge_det;
   logic              win_last;
   logic [CNT_W-1:0]  edge_sum;
   logic [CNT_W:0]    sum_ext;
   logic [CNT_W:0]    abs_diff;
   logic              window_good;

   // Edges seen while the synchronizer is still filling after reset are not trusted.
   assign edge_det = ref_sync2 & ~ref_hist & (prime_cnt == 2'd3);
   assign win_last = (win_cnt == WIN_W'(WINDOW - 1));

   always_comb begin
      edge_sum = edge_cnt;
      if (edge_cnt != {CNT_W{1'b1}}) begin
         edge_sum = edge_cnt + {{(CNT_W-1){1'b0}}, edge_det};
      end
   end

   assign sum_ext = {1'b0, edge_sum};

   always_comb begin
      abs_diff = '0;
      if (sum_ext >= (CNT_W+1)'(EXPECTED)) begin
         abs_diff = sum_ext - (CNT_W+1)'(EXPECTED);
      end else begin
         abs_diff = (CNT_W+1)'(EXPECTED) - sum_ext;
      end
   end

   assign window_good = (abs_diff <= (CNT_W+1)'(TOLERANCE));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ref_sync1 <= 1'b0;
         ref_sync2 <= 1'b0;
         ref_hist  <= 1'b0;
         prime_cnt <= 2'd0;
      end else begin
         ref_sync1 <= ref_clk_in;
         ref_sync2 <= ref_sync1;
         ref_hist  <= ref_sync2;
         if (prime_cnt != 2'd3) begin
            prime_cnt <= prime_cnt + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         win_cnt     <= '0;
         edge_cnt    <= '0;
         good_cnt    <= '0;
         locked      <= 1'b0;
         freq_count  <= '0;
         count_valid <= 1'b0;
         lost_lock   <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         lost_lock   <= 1'b0;
         if (!enable) begin
            // Dropping enable discards the partial window without reporting it.
            state    <= S_IDLE;
            locked   <= 1'b0;
            win_cnt  <= '0;
            edge_cnt <= '0;
            good_cnt <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  state    <= S_ACQUIRE;
                  win_cnt  <= '0;
                  edge_cnt <= '0;
                  good_cnt <= '0;
               end
               S_ACQUIRE, S_LOCKED: begin
                  if (win_last) begin
                     win_cnt     <= '0;
                     edge_cnt    <= '0;
                     freq_count  <= edge_sum;
                     count_valid <= 1'b1;
                     if (window_good) begin
                        if (state == S_ACQUIRE) begin
                           good_cnt <= good_cnt + GOOD_W'(1);
                           if (good_cnt == GOOD_W'(GOOD_WINDOWS - 1)) begin
                              state  <= S_LOCKED;
                              locked <= 1'b1;
                           end
                        end
                     end else begin
                        good_cnt <= '0;
                        if (state == S_LOCKED) begin
                           state     <= S_ACQUIRE;
                           locked    <= 1'b0;
                           lost_lock <= 1'b1;
                        end
                     end
                  end else begin
                     win_cnt  <= win_cnt + WIN_W'(1);
                     edge_cnt <= edge_sum;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: window-table vectors, directed enable/reset cases,
// a small saturating instance, and randomized traffic against a window-sum model.
module tb_pll_lock_monitor;

   localparam int WINDOW   = 1200;
   localparam int EXPECTED = 120;
   localparam int TOL      = 2;
   localparam int GOOD     = 4;
   localparam int CNT_W    = 16;
   localparam int HN       = 65536;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ref_clk_in;
   logic             enable;
   logic             locked;
   logic [CNT_W-1:0] freq_count;
   logic             count_valid;
   logic             lost_lock;

   logic             ref2;
   logic             en2;
   logic             locked2;
   logic [3:0]       freq2;
   logic             cv2;
   logic             ll2;

   always #5 clk = ~clk;

   pll_lock_monitor u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ref_clk_in  (ref_clk_in),
      .enable      (enable),
      .locked      (locked),
      .freq_count  (freq_count),
      .count_valid (count_valid),
      .lost_lock   (lost_lock)
   );

   pll_lock_monitor #(
      .WINDOW(100), .EXPECTED(10), .TOLERANCE(2), .GOOD_WINDOWS(4), .CNT_W(4)
   ) u_sat (
      .clk         (clk),
      .rst_n       (rst_n),
      .ref_clk_in  (ref2),
      .enable      (en2),
      .locked      (locked2),
      .freq_count  (freq2),
      .count_valid (cv2),
      .lost_lock   (ll2)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: inputs captured at each rising edge, evaluated on the falling edge.
   logic s_rst, s_en, s_ref;
   bit   s_valid = 1'b0;

   always @(posedge clk) begin
      s_rst   <= rst_n;
      s_en    <= enable;
      s_ref   <= ref_clk_in;
      s_valid <= 1'b1;
   end

   bit r_hist [0:HN-1];
   bit det    [0:HN-1];
   int n;
   bit m_ready = 1'b0;
   bit m_active, m_locked, m_cv, m_ll;
   int m_freq, streak, wstart;

   always @(negedge clk) begin
      int sum;
      int diff;
      if (s_valid) begin
         if (!s_rst) begin
            n = 0; m_active = 0; m_locked = 0; m_cv = 0; m_ll = 0;
            m_freq = 0; streak = 0; wstart = 0; m_ready = 1;
         end else begin
            m_cv = 0;
            m_ll = 0;
            if (n < HN - 1) n++;
            r_hist[n] = s_ref;
            det[n] = (n >= 4) ? (r_hist[n-2] && !r_hist[n-3]) : 1'b0;
            if (!s_en) begin
               m_active = 0; m_locked = 0; streak = 0;
            end else if (!m_active) begin
               m_active = 1;
               wstart   = n + 1;
            end else if (n == wstart + WINDOW - 1) begin
               sum = 0;
               for (int i = wstart; i <= n; i++) sum += int'(det[i]);
               if (sum > (1 << CNT_W) - 1) sum = (1 << CNT_W) - 1;
               m_freq = sum;
               m_cv   = 1;
               diff   = (sum > EXPECTED) ? sum - EXPECTED : EXPECTED - sum;
               if (diff <= TOL) begin
                  streak++;
                  if (streak >= GOOD) m_locked = 1;
               end else begin
                  if (m_locked) m_ll = 1;
                  m_locked = 0;
                  streak   = 0;
               end
               wstart = n + 1;
            end
         end
         if (m_ready) begin
            chk("model_locked",      locked,      m_locked);
            chk("model_freq_count",  freq_count,  m_freq);
            chk("model_count_valid", count_valid, m_cv);
            chk("model_lost_lock",   lost_lock,   m_ll);
         end
      end
   end

   int cap_freq[$];
   int cap_lock[$];
   int cap_ll[$];

   always @(negedge clk) begin
      if (count_valid === 1'b1) begin
         cap_freq.push_back(int'(freq_count));
         cap_lock.push_back(int'(locked));
         cap_ll.push_back(int'(lost_lock));
      end
   end

   // One window whose rising edges sit well inside the window, giving exactly k edges.
   task automatic drive_window(input int k, input int len);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         ref_clk_in = (i >= 10) && (i < 10 + 8 * k) && (((i - 10) % 8) < 4);
      end
   endtask

   typedef struct {
      int k;
      int exp_freq;
      bit exp_locked;
      bit exp_ll;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int nwin;
      nwin = 0;
      for (int i = 0; i < 50 && rst_n !== 1'b1; i++) @(negedge clk);
      for (int c = 0; c < 700; c++) begin
         @(negedge clk);
         ref2 = ~ref2;
         if (cv2 === 1'b1) begin
            nwin++;
            chk("sat_freq_count", freq2, 15);
            chk("sat_locked", locked2, 0);
            chk("sat_lost_lock", ll2, 0);
         end
      end
      chk("sat_window_count_ok", (nwin >= 5), 1);
      en2 = 1'b0;
   end

   initial begin
      int base, cv_seen, en_off, half, ph, seglen, stuck;

      tbl[0]  = '{120, 120, 0, 0};
      tbl[1]  = '{122, 122, 0, 0};
      tbl[2]  = '{118, 118, 0, 0};
      tbl[3]  = '{121, 121, 1, 0};
      tbl[4]  = '{123, 123, 0, 1};
      tbl[5]  = '{117, 117, 0, 0};
      tbl[6]  = '{122, 122, 0, 0};
      tbl[7]  = '{122, 122, 0, 0};
      tbl[8]  = '{122, 122, 0, 0};
      tbl[9]  = '{122, 122, 1, 0};
      tbl[10] = '{120, 120, 1, 0};
      tbl[11] = '{0,   0,   0, 1};
      tbl[12] = '{120, 120, 0, 0};
      tbl[13] = '{120, 120, 0, 0};
      tbl[14] = '{120, 120, 0, 0};
      tbl[15] = '{120, 120, 1, 0};

      rst_n = 1'b0; enable = 1'b0; ref_clk_in = 1'b0; ref2 = 1'b0; en2 = 1'b0;
      repeat (4) @(negedge clk);
      chk("reset_locked", locked, 0);
      chk("reset_freq_count", freq_count, 0);
      chk("reset_count_valid", count_valid, 0);
      chk("reset_lost_lock", lost_lock, 0);

      rst_n = 1'b1; enable = 1'b1; en2 = 1'b1;
      for (int r = 0; r < 16; r++) drive_window(tbl[r].k, WINDOW);

      // Drop enable mid-window while locked.
      drive_window(120, 600);
      @(negedge clk);
      enable = 1'b0; ref_clk_in = 1'b0;
      @(negedge clk);
      chk("disable_locked", locked, 0);
      chk("disable_count_valid", count_valid, 0);
      chk("disable_freq_held", freq_count, 120);
      cv_seen = 0;
      for (int c = 0; c < 1300; c++) begin
         @(negedge clk);
         if (count_valid === 1'b1) cv_seen++;
      end
      chk("disabled_no_count_valid", cv_seen, 0);
      chk("disabled_freq_held", freq_count, 120);

      chk("table_window_count", cap_freq.size(), 16);
      for (int r = 0; r < 16 && r < cap_freq.size(); r++) begin
         chk($sformatf("table_freq_%0d", r), cap_freq[r], tbl[r].exp_freq);
         chk($sformatf("table_locked_%0d", r), cap_lock[r], tbl[r].exp_locked);
         chk($sformatf("table_lost_%0d", r), cap_ll[r], tbl[r].exp_ll);
      end

      // Reset mid-window, then a full re-acquisition.
      enable = 1'b1;
      repeat (300) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("midreset_locked", locked, 0);
      chk("midreset_freq_count", freq_count, 0);
      chk("midreset_count_valid", count_valid, 0);
      chk("midreset_lost_lock", lost_lock, 0);
      base = cap_freq.size();
      rst_n = 1'b1; enable = 1'b1;
      for (int w = 0; w < 4; w++) drive_window(120, WINDOW);

      // Enable low for exactly the closing cycle of a window.
      drive_window(120, WINDOW - 1);
      chk("reacq_window_count", cap_freq.size() - base, 4);
      for (int w = 0; w < 4 && base + w < cap_freq.size(); w++) begin
         chk($sformatf("reacq_freq_%0d", w), cap_freq[base+w], 120);
         chk($sformatf("reacq_locked_%0d", w), cap_lock[base+w], (w == 3) ? 1 : 0);
      end
      @(negedge clk);
      enable = 1'b0; ref_clk_in = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      chk("closeskip_locked", locked, 0);
      chk("closeskip_count_valid", count_valid, 0);
      repeat (3) @(negedge clk);
      chk("closeskip_no_window", cap_freq.size() - base, 4);

      // Randomized traffic: nominal, off-frequency, jittery and stuck segments.
      en_off = 0; ph = 0;
      for (int seg = 0; seg < 12; seg++) begin
         case ($urandom_range(0, 6))
            0, 1, 2: half = 5;
            3:       half = 6;
            4:       half = 4;
            default: half = 5;
         endcase
         stuck  = ($urandom_range(0, 9) == 0) ? 1 : 0;
         seglen = $urandom_range(1500, 3000);
         for (int c = 0; c < seglen; c++) begin
            @(negedge clk);
            if (stuck != 0) begin
               ref_clk_in = 1'b0;
            end else begin
               ph++;
               if (ph >= half + (($urandom_range(0, 19) == 0) ? 1 : 0)) begin
                  ref_clk_in = ~ref_clk_in;
                  ph = 0;
               end
            end
            if (en_off == 0 && $urandom_range(0, 2999) == 0) en_off = $urandom_range(1, 4);
            enable = (en_off == 0);
            if (en_off > 0) en_off--;
         end
      end

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
